// File: rtl/conv_pkg.sv
// Shared types, constants and the signed-to-pixel conversion for the 3x3 convolution engine.
// Build option CONV3X3_ABS_EN selects edge-magnitude mode (|sum|) for negative sums.
package conv_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COEF_W  = 8;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned OUT_MAX = 255;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  // SobelX, row-major k00..k22.
  localparam coef_t SOBEL_X [9] = '{
    -8'sd1, 8'sd0, 8'sd1,
    -8'sd2, 8'sd0, 8'sd2,
    -8'sd1, 8'sd0, 8'sd1
  };

  // Caller sign-extends the accumulator to 32 bits before conversion.
  function automatic logic [OUT_W-1:0] sat_u8(input logic signed [31:0] s);
    logic signed [31:0] m;
`ifdef CONV3X3_ABS_EN
    m = (s < 0) ? -s : s;
`else
    m = (s < 0) ? 32'sd0 : s;
`endif
    if (m > $signed(32'(OUT_MAX))) begin
      return OUT_W'(OUT_MAX);
    end
    return m[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv3x3_comb_if.sv
// Window/kernel input bundle and registered pixel output of the 3x3 convolution engine.
interface conv3x3_comb_if
  import conv_pkg::*;
#(
  parameter int unsigned BITW = 8
);

  logic            in_valid;
  logic [BITW-1:0] u00, u01, u02;
  logic [BITW-1:0] u10, u11, u12;
  logic [BITW-1:0] u20, u21, u22;
  coef_t           k00, k01, k02;
  coef_t           k10, k11, k12;
  coef_t           k20, k21, k22;
  logic [OUT_W-1:0] y;
  logic            out_valid;

  modport master (
    output in_valid,
    output u00, u01, u02, u10, u11, u12, u20, u21, u22,
    output k00, k01, k02, k10, k11, k12, k20, k21, k22,
    input  y,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  u00, u01, u02, u10, u11, u12, u20, u21, u22,
    input  k00, k01, k02, k10, k11, k12, k20, k21, k22,
    output y,
    output out_valid
  );

endinterface

// File: rtl/conv_mac9.sv
// Nine exact unsigned-by-signed multipliers feeding a balanced adder tree; ACCW-bit signed sum.
module conv_mac9
  import conv_pkg::*;
#(
  parameter int unsigned BITW = 8,
  parameter int unsigned ACCW = 20
) (
  input  logic [BITW-1:0]         u [9],
  input  coef_t                   k [9],
  output logic signed [ACCW-1:0]  sum
);

  localparam int unsigned PRODW = BITW + 9;

  logic signed [PRODW-1:0] prod [9];
  logic signed [ACCW-1:0]  ext  [9];
  logic signed [ACCW-1:0]  s01, s23, s45, s67, s0123, s4567;

  // Zero-extend the pixel by one bit so it multiplies as a non-negative signed value.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod[i] = $signed({1'b0, u[i]}) * k[i];
      ext[i]  = {{(ACCW - PRODW){prod[i][PRODW-1]}}, prod[i]};
    end
  end

  always_comb begin
    s01   = ext[0] + ext[1];
    s23   = ext[2] + ext[3];
    s45   = ext[4] + ext[5];
    s67   = ext[6] + ext[7];
    s0123 = s01 + s23;
    s4567 = s45 + s67;
    sum   = s0123 + s4567 + ext[8];
  end

endmodule

// File: rtl/conv3x3_comb.sv
// 3x3 convolution: combinational MAC, signed-to-pixel conversion, one output register stage.
// Negative-sum handling depends on CONV3X3_ABS_EN (see conv_pkg::sat_u8).
module conv3x3_comb
  import conv_pkg::*;
#(
  parameter int unsigned BITW = 8,
  parameter int unsigned ACCW = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  conv3x3_comb_if.slave  bus
);

  if (ACCW < BITW + 12) begin : g_accw_check
    $error("conv3x3_comb: ACCW must be at least BITW+12");
  end
  if (ACCW > 32) begin : g_accw_max_check
    $error("conv3x3_comb: ACCW must not exceed 32");
  end

  logic [BITW-1:0]        u_win [9];
  coef_t                  k_win [9];
  logic signed [ACCW-1:0] sum;
  logic signed [31:0]     sum32;
  logic [OUT_W-1:0]       y_d, y_q;
  logic                   out_valid_q;

  assign u_win = '{bus.u00, bus.u01, bus.u02,
                   bus.u10, bus.u11, bus.u12,
                   bus.u20, bus.u21, bus.u22};
  assign k_win = '{bus.k00, bus.k01, bus.k02,
                   bus.k10, bus.k11, bus.k12,
                   bus.k20, bus.k21, bus.k22};

  conv_mac9 #(
    .BITW (BITW),
    .ACCW (ACCW)
  ) u_mac (
    .u   (u_win),
    .k   (k_win),
    .sum (sum)
  );

  always_comb begin
    sum32 = 32'(sum);
    y_d   = sat_u8(sum32);
  end

  // y holds across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q <= y_d;
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_conv3x3_comb.sv
// Self-checking bench for conv3x3_comb: directed SobelX/identity cases plus randomized windows.
module tb_conv3x3_comb;
  import conv_pkg::*;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;
  int u [9];
  int k [9];
  int exp_y;
  int exp_v;

  conv3x3_comb_if #(.BITW(8)) bus ();

  conv3x3_comb #(
    .BITW (8),
    .ACCW (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: plain integer dot product, then the pixel conversion rule.
  function automatic int ref_y();
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += u[i] * k[i];
`ifdef CONV3X3_ABS_EN
    if (s < 0) s = -s;
`else
    if (s < 0) s = 0;
`endif
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic drive(input logic v);
    bus.in_valid = v;
    bus.u00 = 8'(u[0]); bus.u01 = 8'(u[1]); bus.u02 = 8'(u[2]);
    bus.u10 = 8'(u[3]); bus.u11 = 8'(u[4]); bus.u12 = 8'(u[5]);
    bus.u20 = 8'(u[6]); bus.u21 = 8'(u[7]); bus.u22 = 8'(u[8]);
    bus.k00 = 8'(k[0]); bus.k01 = 8'(k[1]); bus.k02 = 8'(k[2]);
    bus.k10 = 8'(k[3]); bus.k11 = 8'(k[4]); bus.k12 = 8'(k[5]);
    bus.k20 = 8'(k[6]); bus.k21 = 8'(k[7]); bus.k22 = 8'(k[8]);
  endtask

  // One clock: predict from the inputs presented now, then check 1 time unit after the edge.
  task automatic cycle();
    int   r;
    logic v;
    v = bus.in_valid;
    r = ref_y();
    @(posedge clk);
    #1;
    if (v) exp_y = r;
    exp_v = int'(v);
    check("y", int'(bus.y), exp_y);
    check("out_valid", int'(bus.out_valid), exp_v);
  endtask

  task automatic set_sobel(input int left, input int mid, input int right);
    for (int i = 0; i < 9; i++) begin
      k[i] = int'(SOBEL_X[i]);
      case (i % 3)
        0:       u[i] = left;
        1:       u[i] = mid;
        default: u[i] = right;
      endcase
    end
  endtask

  task automatic directed(input string tag, input int want_abs, input int want_clamp);
    drive(1'b1);
    cycle();
`ifdef CONV3X3_ABS_EN
    check(tag, int'(bus.y), want_abs);
`else
    check(tag, int'(bus.y), want_clamp);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_y    = 0;
    exp_v    = 0;

    // Reset held with live, nonzero inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      u[i] = 200;
      k[i] = 3;
    end
    drive(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", int'(bus.y), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    drive(1'b0);
    cycle();
    cycle();

    set_sobel(100, 100, 100);
    directed("sobel_flat", 0, 0);
    set_sobel(10, 77, 20);
    directed("sobel_pos40", 40, 40);
    set_sobel(20, 3, 10);
    directed("sobel_neg40", 40, 0);
    set_sobel(0, 128, 255);
    directed("sobel_sat", 255, 255);
    for (int i = 0; i < 9; i++) begin
      u[i] = 255;
      k[i] = -128;
    end
    directed("worst_neg", 255, 0);
    for (int i = 0; i < 9; i++) k[i] = 127;
    directed("worst_pos", 255, 255);

    // Identity kernel: y tracks u11 one cycle later.
    for (int i = 0; i < 9; i++) k[i] = 0;
    k[4] = 1;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 9; i++) u[i] = int'($urandom_range(0, 255));
      u[4] = n;
      drive(1'b1);
      cycle();
      check("ident_track", int'(bus.y), n);
    end
    u[4] = 9;
    drive(1'b0);
    cycle();
    check("ident_hold_y", int'(bus.y), 255);
    check("ident_hold_valid", int'(bus.out_valid), 0);

    // Randomized windows, mixing full-range and small kernels, with gaps in in_valid.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++) begin
        u[i] = int'($urandom_range(0, 255));
        if (n % 2 == 0) k[i] = int'($urandom_range(0, 255)) - 128;
        else            k[i] = int'($urandom_range(0, 4)) - 2;
      end
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      cycle();
    end

    // Reset mid-stream is asynchronous and discards the in-flight result.
    set_sobel(10, 0, 20);
    drive(1'b1);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", int'(bus.y), 0);
    check("async_rst_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    exp_y = 0;
    exp_v = 0;
    drive(1'b0);
    cycle();
    set_sobel(10, 5, 20);
    directed("post_rst_first", 40, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_comb.md
Name: conv3x3_comb

Overview:
Single-output 3x3 convolution engine for 8-bit greyscale image filtering (e.g. SobelX edge detection over a 256x256 frame).
- Takes one 3x3 unsigned pixel window and nine signed kernel coefficients per cycle.
- Computes the signed multiply-accumulate, then converts it to an 8-bit output pixel.
- Registers the result once before output.
- Sits after the line-buffer/window generator and before the frame writer.

Parameters:
- BITW, 8: pixel width (unsigned) of u00..u22.
- ACCW, 20: signed accumulator width. Requirement: ACCW >= BITW+12, checked by elaboration-time assertion.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: window/kernel inputs valid this cycle.
- u00..u22, input, BITW each: window pixels, row-major (uRC = row R, column C), unsigned.
- k00..k22, input, 8 each: kernel coefficients, signed two's complement, same indexing as u.
- y, output, 8: filtered output pixel, unsigned 0..255.
- out_valid, output, 1: y holds a new result.

Behaviour:
- Products: pRC = $signed({1'b0,uRC}) * kRC, each BITW+9 bits signed, exact.
- Sum: sum of all nine products, sign-extended to ACCW. Exact; no overflow is possible given the ACCW rule. Worst case is 9*255*128 = 293760.
- Conversion to 8 bits: negative sums follow the optional-feature rule. Non-negative magnitudes > 255 saturate to 255. Otherwise y = low 8 bits.
- Datapath is purely combinational up to one output register stage.
- On each rising clk:
  - If in_valid=1: y <= converted result, out_valid <= 1.
  - If in_valid=0: y holds its value, out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one window per cycle. No backpressure.
- Reset: while rst_n=0, y=0 and out_valid=0 immediately, independent of clk.
  - Asserting reset mid-stream discards any pending result.
  - The first valid output after rst_n rises appears 1 cycle after the first in_valid.
- Inputs are sampled only at the clk edge. Kernel inputs may change every cycle with no restriction.
- Border handling (zeroing edge pixels) is not done here; it is the caller's responsibility.

Optional Feature:
- Macro CONV3X3_ABS_EN.
- Defined: negative sums map to their absolute value (|sum|), then saturate to 255. This is the edge-magnitude mode.
- Undefined: negative sums clamp to 0; positive sums saturate to 255.
- Saturation above 255 is identical in both modes.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W=8, COEF_W=8, OUT_W=8, OUT_MAX=255.
  - Typedefs pix_t (unsigned) and coef_t (signed).
  - Function sat_u8 (ACCW -> 8-bit conversion).
  - SobelX kernel localparams (-1,0,1 / -2,0,2 / -1,0,1) for benches.
- One natural sub-module, conv_mac9: nine multipliers plus an adder tree producing the ACCW signed sum. The top level adds the conversion and output register.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and nonzero inputs -> y=0, out_valid=0. After release, in_valid=0 -> out_valid stays 0.
- SobelX, flat window (all u=100), in_valid=1 -> next cycle y=0, out_valid=1.
- SobelX, left column 10, right column 20, middle anything -> sum = 10+20+10 = 40 -> y=40 after 1 cycle.
- SobelX, left column 20, right column 10 -> sum=-40:
  - With CONV3X3_ABS_EN: y=40.
  - Without: y=0.
- SobelX, left column 0, right column 255 -> sum=1020 -> y=255 (saturate). All k=-128 with all u=255 -> sum=-293760, no overflow: y=255 with ABS_EN, 0 without.
- Identity kernel (k11=1, others 0), streaming u11 = 0,1,...,255 on consecutive cycles with in_valid=1 -> y tracks u11 delayed by one cycle. Dropping in_valid for one cycle -> out_valid=0 and y holds its last value.
